// File: rtl/color_detect_pkg.sv
// Shared colour-detection types: RGB565 pixel, bbox result, FSM states.
// Default frame geometry matches the capture block.
package color_detect_pkg;

  localparam int DEF_IMG_W = 480;
  localparam int DEF_IMG_H = 480;

  localparam int CRD_W = 16;
  localparam int CNT_W = 32;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef struct packed {
    logic             found;
    logic [CNT_W-1:0] count;
    logic [CRD_W-1:0] xmin;
    logic [CRD_W-1:0] xmax;
    logic [CRD_W-1:0] ymin;
    logic [CRD_W-1:0] ymax;
  } bbox_t;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DONE
  } state_t;

  function automatic logic in_box(
    input rgb565_t p,
    input rgb565_t lo,
    input rgb565_t hi
  );
    return (p.r >= lo.r) && (p.r <= hi.r) &&
           (p.g >= lo.g) && (p.g <= hi.g) &&
           (p.b >= lo.b) && (p.b <= hi.b);
  endfunction

endpackage

// File: rtl/rgb565_match.sv
// Registered inclusive three-channel range compare, 1-cycle latency.
// The match flag is qualified by the valid it travels with.
module rgb565_match
  import color_detect_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    valid,
  input  rgb565_t pix,
  input  rgb565_t lo,
  input  rgb565_t hi,
  output logic    valid_q,
  output logic    match_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      match_q <= 1'b0;
    end else begin
      valid_q <= valid;
      match_q <= valid & in_box(pix, lo, hi);
    end
  end

endmodule

// File: rtl/color_bbox.sv
// Per-frame colour bbox/count statistics over an RGB565 pixel stream.
// Optional mask output stream enabled by COLOR_BBOX_MASK_EN.
module color_bbox
  import color_detect_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  localparam int XW = $clog2(IMG_W),
  localparam int YW = $clog2(IMG_H),
  localparam int CW = $clog2(IMG_W*IMG_H+1)
) (
  input  logic          i_pclk,
  input  logic          i_rstn,
  input  logic          i_sof,
  input  logic          i_wr,
  input  logic [15:0]   i_wdata,
  input  logic [15:0]   i_lo,
  input  logic [15:0]   i_hi,
  output logic          o_valid,
  output logic          o_found,
  output logic [CW-1:0] o_count,
  output logic [XW-1:0] o_xmin,
  output logic [XW-1:0] o_xmax,
  output logic [YW-1:0] o_ymin,
  output logic [YW-1:0] o_ymax
`ifdef COLOR_BBOX_MASK_EN
  ,
  output logic          o_mask_wr,
  output logic [15:0]   o_mask_wdata
`endif
);

  localparam logic [XW-1:0] XL = XW'(IMG_W-1);
  localparam logic [YW-1:0] YL = YW'(IMG_H-1);
  localparam logic [CW-1:0] NPIX = CW'(IMG_W*IMG_H);

  state_t st, st_nx;
  rgb565_t lo_q, hi_q, lo_e, hi_e;
  logic [XW-1:0] x_q, px;
  logic [YW-1:0] y_q, py;
  logic acc_pix, last_pix;

  // sof wins over the held coordinates and thresholds in its own cycle
  always_comb begin
    lo_e = i_sof ? rgb565_t'(i_lo) : lo_q;
    hi_e = i_sof ? rgb565_t'(i_hi) : hi_q;
    px = i_sof ? '0 : x_q;
    py = i_sof ? '0 : y_q;
    acc_pix = i_wr && (i_sof || st == ACTIVE);
    last_pix = acc_pix && px == XL && py == YL;
  end

  always_comb begin
    st_nx = st;
    case (st)
      IDLE: if (i_sof) st_nx = ACTIVE;
      ACTIVE: if (i_sof) st_nx = ACTIVE;
      DONE: st_nx = i_sof ? ACTIVE : IDLE;
      default: st_nx = IDLE;
    endcase
    if (last_pix) st_nx = DONE;
  end

  always_ff @(posedge i_pclk or negedge i_rstn) begin
    if (!i_rstn) begin
      st <= IDLE;
      x_q <= '0;
      y_q <= '0;
      lo_q <= '0;
      hi_q <= '0;
    end else begin
      st <= st_nx;
      if (i_sof) begin
        lo_q <= rgb565_t'(i_lo);
        hi_q <= rgb565_t'(i_hi);
      end
      if (acc_pix) begin
        if (px == XL) begin
          x_q <= '0;
          y_q <= (py == YL) ? '0 : py + YW'(1);
        end else begin
          x_q <= px + XW'(1);
          y_q <= py;
        end
      end else if (i_sof) begin
        x_q <= '0;
        y_q <= '0;
      end
    end
  end

  logic s1_v, s1_m, s1_first, s1_last;
  logic [XW-1:0] s1_x;
  logic [YW-1:0] s1_y;

  rgb565_match u_match (
    .clk    (i_pclk),
    .rst_n  (i_rstn),
    .valid  (acc_pix),
    .pix    (rgb565_t'(i_wdata)),
    .lo     (lo_e),
    .hi     (hi_e),
    .valid_q(s1_v),
    .match_q(s1_m)
  );

  always_ff @(posedge i_pclk or negedge i_rstn) begin
    if (!i_rstn) begin
      s1_x <= '0;
      s1_y <= '0;
      s1_first <= 1'b0;
      s1_last <= 1'b0;
    end else begin
      s1_x <= px;
      s1_y <= py;
      s1_first <= acc_pix && px == '0 && py == '0;
      s1_last <= last_pix;
    end
  end

  logic [CW-1:0] cnt;
  logic [XW-1:0] xmin, xmax;
  logic [YW-1:0] ymin, ymax;
  logic s2_last;

  // pixel (0,0) re-seeds the accumulators, so aborted frames leave no trace
  always_ff @(posedge i_pclk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt <= '0;
      xmin <= XL;
      xmax <= '0;
      ymin <= YL;
      ymax <= '0;
      s2_last <= 1'b0;
    end else begin
      s2_last <= s1_v & s1_last;
      if (s1_v) begin
        if (s1_first) begin
          cnt <= s1_m ? CW'(1) : '0;
          xmin <= s1_m ? s1_x : XL;
          xmax <= s1_m ? s1_x : '0;
          ymin <= s1_m ? s1_y : YL;
          ymax <= s1_m ? s1_y : '0;
        end else if (s1_m) begin
          if (cnt != NPIX) cnt <= cnt + CW'(1);
          if (s1_x < xmin) xmin <= s1_x;
          if (s1_x > xmax) xmax <= s1_x;
          if (s1_y < ymin) ymin <= s1_y;
          if (s1_y > ymax) ymax <= s1_y;
        end
      end
    end
  end

  bbox_t res;
  logic res_v, any;

  assign any = cnt != '0;

  // snapshot frees the accumulators for a frame that starts while draining
  always_ff @(posedge i_pclk or negedge i_rstn) begin
    if (!i_rstn) begin
      res <= '0;
      res_v <= 1'b0;
    end else begin
      res_v <= s2_last;
      if (s2_last) begin
        res.found <= any;
        res.count <= CNT_W'(cnt);
        res.xmin <= any ? CRD_W'(xmin) : '0;
        res.xmax <= any ? CRD_W'(xmax) : '0;
        res.ymin <= any ? CRD_W'(ymin) : '0;
        res.ymax <= any ? CRD_W'(ymax) : '0;
      end
    end
  end

  always_ff @(posedge i_pclk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_valid <= 1'b0;
      o_found <= 1'b0;
      o_count <= '0;
      o_xmin <= '0;
      o_xmax <= '0;
      o_ymin <= '0;
      o_ymax <= '0;
    end else begin
      o_valid <= res_v;
      if (res_v) begin
        o_found <= res.found;
        o_count <= res.count[CW-1:0];
        o_xmin <= res.xmin[XW-1:0];
        o_xmax <= res.xmax[XW-1:0];
        o_ymin <= res.ymin[YW-1:0];
        o_ymax <= res.ymax[YW-1:0];
      end
    end
  end

  logic res_unused;
  assign res_unused = ^res;

`ifdef COLOR_BBOX_MASK_EN
  logic [15:0] pix_q;

  always_ff @(posedge i_pclk or negedge i_rstn) begin
    if (!i_rstn) begin
      pix_q <= '0;
    end else if (acc_pix) begin
      pix_q <= i_wdata;
    end
  end

  assign o_mask_wr = s1_v;
  assign o_mask_wdata = s1_m ? 16'hFFFF : pix_q;
`endif

endmodule

// File: tb/tb_color_bbox.sv
// Scoreboard bench for color_bbox on an 8x4 frame.
// Mask stream is also checked when COLOR_BBOX_MASK_EN is defined.
module tb_color_bbox;

  localparam int W = 8;
  localparam int H = 4;
  localparam int N = W * H;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sof = 1'b0;
  logic wr = 1'b0;
  logic [15:0] wdata = '0;
  logic [15:0] lo = '0;
  logic [15:0] hi = '0;
  logic o_valid, o_found;
  logic [5:0] o_count;
  logic [2:0] o_xmin, o_xmax;
  logic [1:0] o_ymin, o_ymax;
`ifdef COLOR_BBOX_MASK_EN
  logic mwr;
  logic [15:0] mdata;
`endif

  color_bbox #(.IMG_W(W), .IMG_H(H)) dut (
    .i_pclk (clk),
    .i_rstn (rst_n),
    .i_sof  (sof),
    .i_wr   (wr),
    .i_wdata(wdata),
    .i_lo   (lo),
    .i_hi   (hi),
    .o_valid(o_valid),
    .o_found(o_found),
    .o_count(o_count),
    .o_xmin (o_xmin),
    .o_xmax (o_xmax),
    .o_ymin (o_ymin),
    .o_ymax (o_ymax)
`ifdef COLOR_BBOX_MASK_EN
    ,
    .o_mask_wr   (mwr),
    .o_mask_wdata(mdata)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    bit found;
    int count, xmin, xmax, ymin, ymax, at;
  } exp_t;

  exp_t exp_q[$];
  logic [15:0] mask_q[$];
  int vec = 0;
  int miss = 0;

  bit in_frame = 0;
  int mx, my, m_cnt, m_xmin, m_xmax, m_ymin, m_ymax;
  logic [15:0] lo_s, hi_s;
  logic [15:0] fb[N];

  function automatic bit tb_match(logic [15:0] p, logic [15:0] l, logic [15:0] h);
    return p[15:11] >= l[15:11] && p[15:11] <= h[15:11] &&
           p[10:5] >= l[10:5] && p[10:5] <= h[10:5] &&
           p[4:0] >= l[4:0] && p[4:0] <= h[4:0];
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (o_valid) begin
      if (exp_q.size() == 0) begin
        vec++; miss++;
        $display("FAIL unexpected_valid at cycle %0d", cyc);
      end else begin
        e = exp_q.pop_front();
        vec++; if (cyc != e.at) begin miss++; $display("FAIL latency got cycle %0d want %0d", cyc, e.at); end
        vec++; if (o_found !== e.found) begin miss++; $display("FAIL found got %0d want %0d", o_found, e.found); end
        vec++; if (int'(o_count) !== e.count) begin miss++; $display("FAIL count got %0d want %0d", o_count, e.count); end
        vec++; if (int'(o_xmin) !== e.xmin) begin miss++; $display("FAIL xmin got %0d want %0d", o_xmin, e.xmin); end
        vec++; if (int'(o_xmax) !== e.xmax) begin miss++; $display("FAIL xmax got %0d want %0d", o_xmax, e.xmax); end
        vec++; if (int'(o_ymin) !== e.ymin) begin miss++; $display("FAIL ymin got %0d want %0d", o_ymin, e.ymin); end
        vec++; if (int'(o_ymax) !== e.ymax) begin miss++; $display("FAIL ymax got %0d want %0d", o_ymax, e.ymax); end
      end
    end
`ifdef COLOR_BBOX_MASK_EN
    if (mwr) begin
      vec++;
      if (mask_q.size() == 0) begin
        miss++; $display("FAIL unexpected_mask_wr at cycle %0d", cyc);
      end else if (mdata !== mask_q[0]) begin
        miss++; $display("FAIL mask got %h want %h", mdata, mask_q[0]);
        void'(mask_q.pop_front());
      end else begin
        void'(mask_q.pop_front());
      end
    end
`endif
  end

  task automatic step(input bit s, input bit w, input logic [15:0] d);
    logic [15:0] l, h;
    bit m;
    exp_t e;
    l = lo;
    h = hi;
    sof = s; wr = w; wdata = d;
    @(posedge clk); #1;
    sof = 0; wr = 0;
    if (s) begin
      lo_s = l; hi_s = h;
      in_frame = 1; mx = 0; my = 0;
      m_cnt = 0; m_xmin = W - 1; m_xmax = 0; m_ymin = H - 1; m_ymax = 0;
    end
    if (w && in_frame) begin
      m = tb_match(d, lo_s, hi_s);
      mask_q.push_back(m ? 16'hFFFF : d);
      if (m) begin
        m_cnt++;
        if (mx < m_xmin) m_xmin = mx;
        if (mx > m_xmax) m_xmax = mx;
        if (my < m_ymin) m_ymin = my;
        if (my > m_ymax) m_ymax = my;
      end
      if (mx == W - 1 && my == H - 1) begin
        e.found = m_cnt != 0;
        e.count = m_cnt;
        e.xmin = e.found ? m_xmin : 0;
        e.xmax = e.found ? m_xmax : 0;
        e.ymin = e.found ? m_ymin : 0;
        e.ymax = e.found ? m_ymax : 0;
        e.at = cyc + 3;
        exp_q.push_back(e);
        in_frame = 0;
      end
      if (mx == W - 1) begin mx = 0; my++; end
      else mx++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 16'h0);
  endtask

  task automatic send_fb(input bit sof_first);
    if (sof_first) step(1, 1, fb[0]);
    else begin
      step(1, 0, 16'h0);
      step(0, 1, fb[0]);
    end
    for (int i = 1; i < N; i++) step(0, 1, fb[i]);
  endtask

  task automatic check_zero(input string tag);
    vec++;
    if ({o_valid, o_found, o_count, o_xmin, o_xmax, o_ymin, o_ymax} !== '0) begin
      miss++;
      $display("FAIL %s outputs got v%0d f%0d c%0d x%0d..%0d y%0d..%0d want all 0",
               tag, o_valid, o_found, o_count, o_xmin, o_xmax, o_ymin, o_ymax);
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1;
    idle(2);
  endtask

  task automatic test_full();
    lo = 16'h0000; hi = 16'hFFFF;
    for (int i = 0; i < N; i++) fb[i] = 16'($urandom);
    send_fb(0);
    idle(6);
  endtask

  task automatic test_single();
    lo = 16'hF800; hi = 16'hF800;
    for (int i = 0; i < N; i++) fb[i] = 16'h001F;
    fb[2 * W + 5] = 16'hF800;
    send_fb(0);
    idle(6);
  endtask

  task automatic test_reset_mid();
    lo = 16'h0000; hi = 16'hFFFF;
    step(1, 0, 16'h0);
    for (int i = 0; i < 10; i++) step(0, 1, 16'($urandom));
    idle(2);
    rst_n = 0;
    in_frame = 0;
    #2;
    check_zero("reset_mid");
    @(posedge clk); #1;
    rst_n = 1;
    idle(8);
    check_zero("after_reset_mid");
  endtask

  task automatic test_none();
    lo = 16'hF800; hi = 16'hF800;
    for (int i = 0; i < N; i++) fb[i] = 16'h001F;
    send_fb(0);
    idle(6);
    lo = 16'h07E0; hi = 16'h0000;
    for (int i = 0; i < N; i++) fb[i] = 16'($urandom);
    send_fb(1);
    idle(6);
  endtask

  task automatic test_abort();
    lo = 16'hF800; hi = 16'hF800;
    step(1, 0, 16'h0);
    for (int i = 0; i < 20; i++) step(0, 1, 16'hF800);
    for (int i = 0; i < N; i++) fb[i] = 16'h001F;
    fb[3 * W + 3] = 16'hF800;
    send_fb(0);
    idle(6);
  endtask

  task automatic test_thresh();
    lo = 16'hF800; hi = 16'hF800;
    step(1, 0, 16'h0);
    lo = 16'h0000; hi = 16'hFFFF;
    for (int i = 0; i < N; i++) step(0, 1, (i == 9) ? 16'hF800 : 16'h001F);
    idle(2);
    lo = 16'h07E0; hi = 16'h07E0;
    for (int i = 0; i < N; i++) fb[i] = 16'h001F;
    fb[0] = 16'h07E0;
    send_fb(1);
    idle(6);
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 4; f++) begin
      lo = {5'($urandom_range(0, 15)), 6'($urandom_range(0, 31)), 5'($urandom_range(0, 15))};
      hi = {5'($urandom_range(10, 31)), 6'($urandom_range(20, 63)), 5'($urandom_range(10, 31))};
      for (int i = 0; i < N; i++) fb[i] = 16'($urandom);
      send_fb(1);
    end
    for (int i = 0; i < 5; i++) step(0, 1, 16'hFFFF);
    idle(6);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_full();
    test_single();
    test_reset_mid();
    test_none();
    test_abort();
    test_thresh();
    test_back_to_back();
    idle(4);
    vec++;
    if (exp_q.size() != 0) begin
      miss++;
      $display("FAIL missing_valid got %0d pending want 0", exp_q.size());
    end
`ifdef COLOR_BBOX_MASK_EN
    vec++;
    if (mask_q.size() != 0) begin
      miss++;
      $display("FAIL missing_mask got %0d pending want 0", mask_q.size());
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
